// File: rtl/block_cache.sv
// Direct-mapped, read-only block cache: four-word lines filled from a
// fixed-latency combinational memory, with saturating hit/access counters.
module block_cache #(
    parameter int TAG_W        = 3,
    parameter int INDEX_W      = 10,
    parameter int MISS_LATENCY = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    input  logic [TAG_W+INDEX_W+1:0]  req_addr,
    output logic                      req_ready,
    output logic                      resp_valid,
    output logic [31:0]               resp_data,
    output logic                      resp_hit,
    output logic [TAG_W+INDEX_W+1:0]  mem_addr,
    input  logic [31:0]               mem_data0,
    input  logic [31:0]               mem_data1,
    input  logic [31:0]               mem_data2,
    input  logic [31:0]               mem_data3,
    output logic [15:0]               hit_count,
    output logic [15:0]               access_count,
    output logic [1:0]                dbg_state
);

    localparam int ADDR_W = TAG_W + INDEX_W + 2;
    localparam int LINES  = 1 << INDEX_W;

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_COMPARE   = 2'd1;
    localparam logic [1:0] S_MISS_WAIT = 2'd2;
    localparam logic [1:0] S_RESPOND   = 2'd3;

    localparam logic [3:0]  WAIT_LAST = 4'(MISS_LATENCY - 1);
    localparam logic [15:0] CNT_MAX   = 16'hFFFF;

    // Handshake: a request is taken on any rising edge where req_valid and
    // req_ready are both high; req_valid while req_ready is low is ignored.

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic [31:0]       resp_data_q, resp_data_d;
    logic              resp_hit_q, resp_hit_d;
    logic [15:0]       hit_count_q, hit_count_d;
    logic [15:0]       access_count_q, access_count_d;
    logic [LINES-1:0]  valid_q, valid_d;

    logic [31:0]       data_mem [LINES][4];
    logic [TAG_W-1:0]  tag_mem  [LINES];

    logic [INDEX_W-1:0] line_idx;
    logic [TAG_W-1:0]   line_tag;
    logic [1:0]         word_off;
    logic               lookup_hit;
    logic               fill_en;
    logic [31:0]        fill_word;

    assign line_idx   = addr_q[INDEX_W+1:2];
    assign line_tag   = addr_q[ADDR_W-1:INDEX_W+2];
    assign word_off   = addr_q[1:0];
    assign lookup_hit = valid_q[line_idx] && (tag_mem[line_idx] == line_tag);
    assign fill_en    = (state_q == S_MISS_WAIT) && (wait_cnt_q == WAIT_LAST);

    always_comb begin
        fill_word = mem_data0;
        case (word_off)
            2'd0: fill_word = mem_data0;
            2'd1: fill_word = mem_data1;
            2'd2: fill_word = mem_data2;
            2'd3: fill_word = mem_data3;
            default: fill_word = mem_data0;
        endcase
    end

    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        wait_cnt_d     = wait_cnt_q;
        resp_data_d    = resp_data_q;
        resp_hit_d     = resp_hit_q;
        hit_count_d    = hit_count_q;
        access_count_d = access_count_q;
        valid_d        = valid_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    state_d = S_COMPARE;
                    if (access_count_q != CNT_MAX) begin
                        access_count_d = access_count_q + 16'd1;
                    end
                end
            end
            S_COMPARE: begin
                if (lookup_hit) begin
                    resp_data_d = data_mem[line_idx][word_off];
                    resp_hit_d  = 1'b1;
                    state_d     = S_RESPOND;
                    if (hit_count_q != CNT_MAX) begin
                        hit_count_d = hit_count_q + 16'd1;
                    end
                end else begin
                    wait_cnt_d = 4'd0;
                    state_d    = S_MISS_WAIT;
                end
            end
            S_MISS_WAIT: begin
                wait_cnt_d = wait_cnt_q + 4'd1;
                if (fill_en) begin
                    valid_d[line_idx] = 1'b1;
                    resp_data_d       = fill_word;
                    resp_hit_d        = 1'b0;
                    state_d           = S_RESPOND;
                end
            end
            S_RESPOND: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            addr_q         <= '0;
            wait_cnt_q     <= '0;
            resp_data_q    <= '0;
            resp_hit_q     <= 1'b0;
            hit_count_q    <= '0;
            access_count_q <= '0;
            valid_q        <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            wait_cnt_q     <= wait_cnt_d;
            resp_data_q    <= resp_data_d;
            resp_hit_q     <= resp_hit_d;
            hit_count_q    <= hit_count_d;
            access_count_q <= access_count_d;
            valid_q        <= valid_d;
        end
    end

    // Line storage is not reset; the valid vector alone decides whether it is used.
    always_ff @(posedge clk) begin
        if (fill_en && !rst) begin
            data_mem[line_idx][0] <= mem_data0;
            data_mem[line_idx][1] <= mem_data1;
            data_mem[line_idx][2] <= mem_data2;
            data_mem[line_idx][3] <= mem_data3;
            tag_mem[line_idx]     <= line_tag;
        end
    end

    assign req_ready    = (state_q == S_IDLE);
    assign resp_valid   = (state_q == S_RESPOND);
    assign resp_data    = resp_data_q;
    assign resp_hit     = resp_hit_q;
    assign mem_addr     = {addr_q[ADDR_W-1:2], 2'b00};
    assign hit_count    = hit_count_q;
    assign access_count = access_count_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_block_cache.sv
// Bench for block_cache: directed scenarios plus randomized reads checked
// against a line-level model of tags, valid bits and counters.
module tb_block_cache;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [14:0] req_addr;
  logic        req_ready;
  logic        resp_valid;
  logic [31:0] resp_data;
  logic        resp_hit;
  logic [14:0] mem_addr;
  logic [31:0] mem_data0, mem_data1, mem_data2, mem_data3;
  logic [15:0] hit_count;
  logic [15:0] access_count;
  logic [1:0]  dbg_state;

  int n_cmp = 0;
  int n_bad = 0;

  // model state: which tag each line holds, plus counters
  bit m_valid [1024];
  int m_tag   [1024];
  int m_hits;
  int m_acc;

  block_cache #(.TAG_W(3), .INDEX_W(10), .MISS_LATENCY(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_ready    (req_ready),
    .resp_valid   (resp_valid),
    .resp_data    (resp_data),
    .resp_hit     (resp_hit),
    .mem_addr     (mem_addr),
    .mem_data0    (mem_data0),
    .mem_data1    (mem_data1),
    .mem_data2    (mem_data2),
    .mem_data3    (mem_data3),
    .hit_count    (hit_count),
    .access_count (access_count),
    .dbg_state    (dbg_state)
  );

  // clock/reset block
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // main memory: word at address a is 0xA000_0000 | a
  function automatic logic [31:0] word_of(input logic [14:0] a);
    return 32'hA000_0000 | {17'd0, a};
  endfunction

  assign mem_data0 = word_of(mem_addr | 15'd0);
  assign mem_data1 = word_of(mem_addr | 15'd1);
  assign mem_data2 = word_of(mem_addr | 15'd2);
  assign mem_data3 = word_of(mem_addr | 15'd3);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) m_valid[i] = 1'b0;
    m_hits = 0;
    m_acc  = 0;
  endtask

  task automatic check_reset_outputs();
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_hit", 32'(resp_hit), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_hit_count", 32'(hit_count), 32'd0);
    check("rst_access_count", 32'(access_count), 32'd0);
  endtask

  // driver: one read; hold keeps req_valid high until the response has passed
  task automatic do_read(input logic [14:0] a, input bit hold);
    int  idx;
    bit  exp_hit;
    int  exp_lat;
    int  lat;
    bit  seen;
    idx = int'(a[11:2]);
    @(negedge clk);
    check("ready_before", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = a;
    exp_hit = m_valid[idx] && (m_tag[idx] == int'(a[14:12]));
    if (m_acc < 65535) m_acc++;
    if (exp_hit && m_hits < 65535) m_hits++;
    if (!exp_hit) begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = int'(a[14:12]);
    end
    exp_lat = exp_hit ? 2 : LAT + 2;
    @(posedge clk);
    if (!hold) #1 req_valid = 1'b0;
    lat  = 0;
    seen = 1'b0;
    for (int c = 1; c <= LAT + 10 && !seen; c++) begin
      @(negedge clk);
      check("ready_low", 32'(req_ready), 32'd0);
      if (resp_valid) begin
        seen = 1'b1;
        lat  = c;
      end
    end
    check("resp_seen", 32'(seen), 32'd1);
    if (seen) begin
      check("latency", 32'(lat), 32'(exp_lat));
      check("resp_data", resp_data, word_of(a));
      check("resp_hit", 32'(resp_hit), 32'(exp_hit));
      check("access_count", 32'(access_count), 32'(m_acc));
      check("hit_count", 32'(hit_count), 32'(m_hits));
    end
    @(negedge clk);
    check("pulse_end", 32'(resp_valid), 32'd0);
    check("ready_after", 32'(req_ready), 32'd1);
    req_valid = 1'b0;
  endtask

  initial begin
    logic [14:0] a;
    int pulses;
    int idx_pool [5];
    idx_pool = '{0, 1, 2, 3, 1023};

    rst       = 1'b1;
    req_valid = 1'b0;
    req_addr  = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs();
    check("rst_state", 32'(dbg_state), 32'd0);

    // cold miss, then hits in the same block
    do_read(15'h0005, 1'b0);
    do_read(15'h0006, 1'b0);
    do_read(15'h0007, 1'b0);
    check("hits_after_block", 32'(hit_count), 32'd2);

    // conflict on index 1: tag 1 evicts tag 0, which then refills
    do_read(15'h1004, 1'b0);
    do_read(15'h0004, 1'b0);
    do_read(15'h0004, 1'b0);
    check("hits_after_conflict", 32'(hit_count), 32'd3);

    // req_valid held high through a miss yields one response only
    do_read(15'h0200, 1'b1);
    check("held_one_access", 32'(access_count), 32'(m_acc));

    // reset during the third MISS_WAIT cycle aborts the miss
    @(negedge clk);
    req_valid = 1'b1;
    req_addr  = 15'h2345;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (4) @(negedge clk);
    check("in_miss_wait", 32'(dbg_state), 32'd2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    pulses = 0;
    check_reset_outputs();
    for (int c = 0; c < LAT + 6; c++) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    check("abort_no_resp", 32'(pulses), 32'd0);
    do_read(15'h2345, 1'b0);
    do_read(15'h0005, 1'b0);

    // reset and request together: request dropped
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 1'b1;
    req_addr  = 15'h0005;
    @(negedge clk);
    rst       = 1'b0;
    req_valid = 1'b0;
    model_reset();
    pulses = 0;
    for (int c = 0; c < LAT + 6; c++) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    check("rst_req_no_resp", 32'(pulses), 32'd0);
    check("rst_req_no_access", 32'(access_count), 32'd0);
    do_read(15'h0005, 1'b0);

    // randomized reads over a few indexes to mix hits and conflicts
    for (int n = 0; n < 60; n++) begin
      a = {3'($urandom_range(0, 7)), 10'(idx_pool[$urandom_range(0, 4)]), 2'($urandom_range(0, 3))};
      do_read(a, ($urandom_range(0, 3) == 0));
    end

    // saturation: preload both counters near the top, then keep hitting
    do_read(15'h0100, 1'b0);
    @(negedge clk);
    force dut.hit_count_q    = 16'hFFFB;
    force dut.access_count_q = 16'hFFFB;
    #1;
    release dut.hit_count_q;
    release dut.access_count_q;
    m_hits = 32'hFFFB;
    m_acc  = 32'hFFFB;
    for (int n = 0; n < 8; n++) begin
      do_read(15'h0100 | 15'(n % 4), 1'b0);
    end
    check("sat_hit_count", 32'(hit_count), 32'h0000_FFFF);
    check("sat_access_count", 32'(access_count), 32'h0000_FFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/block_cache.md
# block_cache

Direct-mapped, read-only block cache sitting between the processor's load path and the main memory model. It takes 15-bit word addresses and serves hits from internal storage. On a miss it drives a block address to main memory, waits a fixed latency, samples the four-word block, installs it and returns the requested word. It also keeps hit and access counters for hit-rate measurement.

## Interface
- TAG_W, 3: tag bits (address[14:12])
- INDEX_W, 10: index bits (address[11:2]); 1024 lines of 4 words
- MISS_LATENCY, 4: wait cycles before memory data is sampled; legal range 1..15
- clk  in  1  rising-edge clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  1  read request present
- req_addr  in  15  word address
- req_ready  out  1  block can accept a request
- resp_valid  out  1  one-cycle pulse, response data valid
- resp_data  out  32  requested word
- resp_hit  out  1  qualifies resp_valid: 1 = hit, 0 = miss-fill
- mem_addr  out  15  block address to main memory, {tag,index,2'b00}
- mem_data0..mem_data3  in  32 each  words at offsets 0..3 of mem_addr's block (combinational memory)
- hit_count  out  16  hits since reset, saturating
- access_count  out  16  accepted requests since reset, saturating

## Operation
- Storage: data[1024][4] x 32b, tag[1024] x 3b, valid[1024]. Only valid is reset.
- FSM states: IDLE, COMPARE, MISS_WAIT, RESPOND.
- IDLE:
  - req_ready=1.
  - On req_valid, register req_addr into addr_q, increment access_count, go to COMPARE.
- COMPARE:
  - Hit when valid[index] && tag[index]==addr_q[14:12].
  - On hit: load resp_data=data[index][offset] and resp_hit=1, increment hit_count, go to RESPOND.
  - On miss: clear wait counter, go to MISS_WAIT.
- MISS_WAIT:
  - Counter increments each cycle.
  - On the cycle the counter equals MISS_LATENCY-1:
    - write mem_data0..3 into data[index][0..3], tag[index]=addr_q[14:12], valid[index]=1;
    - load resp_data=mem_dataN with N=addr_q[1:0], resp_hit=0;
    - go to RESPOND.
- RESPOND: resp_valid=1 for exactly this cycle, then go to IDLE.
- req_ready=0 in every state except IDLE. req_valid outside IDLE is ignored and not queued.
- mem_addr={addr_q[14:2],2'b00} in all states. The bench's memory model must hold data stable throughout MISS_WAIT.
- Counters saturate at 16'hFFFF and do not wrap.
- Fills overwrite the line unconditionally. No dirty state and no write path.

## Timing
- Reset values:
  - state=IDLE, req_ready=1, resp_valid=0, resp_data=0, resp_hit=0;
  - mem_addr=0, hit_count=0, access_count=0;
  - all valid bits=0.
- Request accepted at edge E (IDLE, req_valid=1).
- Hit: COMPARE in cycle E+1, resp_valid high in cycle E+2. Latency 2; next request accepted at E+3.
- Miss: COMPARE E+1, MISS_WAIT E+2..E+1+MISS_LATENCY, resp_valid in E+2+MISS_LATENCY. Latency MISS_LATENCY+2.
- Memory data sampled at the rising edge ending the last MISS_WAIT cycle.
- rst in any state takes effect at the next edge:
  - in-flight request aborted, no response, no fill;
  - counters zeroed, all lines invalidated.
- rst and req_valid together: the request is dropped.
- Back-to-back requests to the same block: the first misses, the second hits.
- Conflict miss: same index, different tag → refill replaces the old line.

## Test plan
- Reset, then read 0x0005. Bench memory returns word = 0xA000_0000|addr. Required: miss, resp_valid at E+6 (MISS_LATENCY=4), resp_data=0xA000_0005, resp_hit=0, hit_count=0, access_count=1.
- Then read 0x0006 and 0x0007 (same block). Required: hits at E+2 with data 0xA000_0006 and 0xA000_0007, hit_count=2.
- Conflict: read 0x1004 (same index as 0x0004, tag 1) → miss. Then 0x0004 → miss again. Then 0x0004 → hit. Required: hit_count +1 only.
- req_valid held high through a miss. Required: exactly one response; req_ready low E+1..E+6; next accept at E+7.
- rst asserted during the third MISS_WAIT cycle. Required: no resp_valid, counters 0. Re-reading the same address misses.
- 65540 hits to one cached address. Required: hit_count and access_count stick at 0xFFFF.
